// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and default sizing for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 1;

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - DIGIT-bit combinational ripple adder slice
module add_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             ci_i,
  output logic [DIGIT-1:0] s_o,
  output logic             co_o,
  output logic             cm_o
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = ci_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o = c[DIGIT];
  // carry into the slice MSB; at the last step this is the carry into bit WIDTH-1
  assign cm_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add/subtract unit with valid/ready handshakes
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0]       slice_s;
  logic                   slice_co, slice_cm;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  add_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i (a_q[DIGIT-1:0]),
    .b_i (b_q[DIGIT-1:0]),
    .ci_i(carry_q),
    .s_o (slice_s),
    .co_o(slice_co),
    .cm_o(slice_cm)
  );

  // new slice enters at the top; after STEPS shifts it lands LSB-first in place
  assign sum_cat = {slice_s, sum_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = slice_co;
        cout_d  = slice_co;
        ovf_d   = slice_co ^ slice_cm;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be >= 1.
REQ-002 Parameter DIGIT, default 1, bits added per clock; SHALL divide WIDTH exactly (elaboration error otherwise); STEPS = WIDTH/DIGIT.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (subtract).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result word.
- cout  out  1  carry-out; for subtract, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-006 Accept occurs when in_valid&&in_ready at a rising edge: latch a, b^{WIDTH{sub}} and c0 = cin^sub, clear the step counter, go to BUSY.
REQ-007 The result SHALL be a + b + cin (add) or a - b - cin (subtract), truncated to WIDTH bits.
REQ-008 In BUSY, each edge SHALL add one DIGIT-bit slice, LSB slice first, using the registered carry, writing the slice of sum and updating the carry.
REQ-009 After the STEPS-th BUSY edge the FSM SHALL enter DONE; out_valid rises exactly STEPS edges after the accepting edge.
REQ-010 cout SHALL be the carry out of bit WIDTH-1.
REQ-011 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-012 sum, cout and ovf SHALL hold stable throughout DONE, whatever the state of out_ready.
REQ-013 On out_valid&&out_ready the FSM SHALL return to IDLE; no new accept is possible in that same cycle, so the minimum issue interval is STEPS+2 cycles.
REQ-014 Changes to a, b, cin and sub outside the accepting edge SHALL NOT affect the result.
REQ-015 in_valid while BUSY or DONE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-016 rst sampled high at an edge SHALL force IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry=0 and counter=0.
REQ-017 rst SHALL take priority over any handshake in the same cycle, and SHALL discard an operation in progress in BUSY or DONE without producing a result.

Structure
REQ-018 A shared package serial_adder_pkg SHALL hold the FSM state enum and the default WIDTH/DIGIT constants.
REQ-019 One sub-module, add_slice (DIGIT-bit combinational ripple adder: a, b, ci -> s, co, plus carry into its MSB), SHALL be instantiated once.
REQ-020 The counter SHALL be $clog2(STEPS+1) bits wide, and the operand shift registers SHALL be WIDTH bits wide.

Verification
REQ-021 WIDTH=1, DIGIT=1, sub=0, all 8 {a,b,cin} combinations -> {cout,sum} matches the one-bit full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1).
REQ-022 WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0, add -> sum=0x00, cout=1, ovf=0; out_valid exactly 8 edges after accept.
REQ-023 WIDTH=8, DIGIT=4: a=0x7F, b=0x01, add -> sum=0x80, cout=0, ovf=1, latency 2; then a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0, ovf=0.
REQ-024 Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; pulse out_ready -> IDLE next edge; in_valid held high -> next accept on the following edge.
REQ-025 Assert rst for one cycle in the middle of BUSY -> next cycle IDLE with all outputs 0, no out_valid pulse; a fresh request then completes correctly.
REQ-026 Random back-to-back requests (WIDTH=16, DIGIT in {1,2,4,16}) compared against an arithmetic reference model, with out_ready toggled randomly -> zero mismatches.
